// File: rtl/wddl_pkg.sv
// wddl_pkg: shared WDDL state encoding, precharge rail value and rail complement helper
package wddl_pkg;

  typedef enum logic [2:0] {
    PRE  = 3'b001,
    EVAL = 3'b010,
    HOLD = 3'b100
  } state_t;

  // {true rail, false rail} during precharge
  localparam logic [1:0] WDDL_PRECHARGE = 2'b00;
  localparam int RAIL_MAXW = 64;

  // Equivalent to &(p ^ n) over the low w bits
  function automatic logic rails_complementary(input logic [RAIL_MAXW-1:0] p,
                                               input logic [RAIL_MAXW-1:0] n,
                                               input int w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < RAIL_MAXW; i++)
      if (i < w && p[i] == n[i]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/wddl_rail_chk.sv
// wddl_rail_chk: combinational check that every dual-rail pair is complementary
module wddl_rail_chk
  import wddl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d_p,
  input  logic [WIDTH-1:0] d_n,
  output logic             ok
);

  assign ok = rails_complementary(RAIL_MAXW'(d_p), RAIL_MAXW'(d_n), WIDTH);

endmodule

// File: rtl/wddl_dr_stage_reg.sv
// wddl_dr_stage_reg: WDDL dual-rail pipeline register enforcing precharge/evaluate waves
// Optional sticky rail complement check enabled by defining WDDL_RAIL_CHECK_EN.
module wddl_dr_stage_reg
  import wddl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int EVAL_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_p_in,
  input  logic [WIDTH-1:0] d_n_in,
  output logic             prech_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_p_out,
  output logic [WIDTH-1:0] d_n_out,
  output logic             rail_err
);

  localparam int CW = $clog2(EVAL_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(EVAL_CYC - 1);

  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic capture;

  always_comb begin
    capture   = (state == EVAL) && in_valid && (cnt == LAST);
    in_ready  = capture;
    prech_out = state != EVAL;
    out_valid = state == HOLD;
    // Any illegal one-hot code falls back to PRE
    state_nx  = capture ? HOLD :
                (state == EVAL) ? EVAL :
                (state == HOLD && !out_ready) ? HOLD :
                (state == PRE) ? EVAL : PRE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= PRE;
      cnt     <= '0;
      d_p_out <= {WIDTH{WDDL_PRECHARGE[1]}};
      d_n_out <= {WIDTH{WDDL_PRECHARGE[0]}};
    end else begin
      state   <= state_nx;
      cnt     <= (state == EVAL && in_valid && !capture) ? cnt + CW'(1) : '0;
      d_p_out <= capture ? d_p_in : (state_nx == HOLD) ? d_p_out : {WIDTH{WDDL_PRECHARGE[1]}};
      d_n_out <= capture ? d_n_in : (state_nx == HOLD) ? d_n_out : {WIDTH{WDDL_PRECHARGE[0]}};
    end
  end

`ifdef WDDL_RAIL_CHECK_EN
  logic rails_ok;

  wddl_rail_chk #(.WIDTH(WIDTH)) u_rail_chk (
    .d_p (d_p_in),
    .d_n (d_n_in),
    .ok  (rails_ok)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) rail_err <= 1'b0;
    else if (capture && !rails_ok) rail_err <= 1'b1;
  end
`else
  assign rail_err = 1'b0;
`endif

endmodule

// File: tb/tb_wddl_dr_stage_reg.sv
// tb_wddl_dr_stage_reg: vector table, random run against a reference model, rail error sequence
module tb_wddl_dr_stage_reg;

  localparam int WIDTH    = 8;
  localparam int EVAL_CYC = 2;
`ifdef WDDL_RAIL_CHECK_EN
  localparam bit RAIL_CHK = 1'b1;
`else
  localparam bit RAIL_CHK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] d_p_in = '0, d_n_in = '0;
  logic in_ready, prech_out, out_valid, rail_err;
  logic [7:0] d_p_out, d_n_out;
  int checks = 0, failures = 0;

  wddl_dr_stage_reg #(.WIDTH(WIDTH), .EVAL_CYC(EVAL_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d_p_in(d_p_in), .d_n_in(d_n_in), .prech_out(prech_out), .out_valid(out_valid),
    .out_ready(out_ready), .d_p_out(d_p_out), .d_n_out(d_n_out), .rail_err(rail_err)
  );

  always #5 clk = ~clk;

  // Reference: phase 0=precharge 1=evaluate 2=holding, run = consecutive valid cycles seen
  int m_phase = 0, m_run = 0;
  logic [7:0] m_p = '0, m_n = '0;
  bit m_err = 1'b0, m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase <= 0; m_run <= 0; m_p <= '0; m_n <= '0; m_err <= 1'b0; m_valid <= 1'b1;
    end else if (m_phase == 0) begin
      m_phase <= 1;
    end else if (m_phase == 1) begin
      if (!in_valid) m_run <= 0;
      else if (m_run + 1 == EVAL_CYC) begin
        m_phase <= 2; m_run <= 0; m_p <= d_p_in; m_n <= d_n_in;
        if (RAIL_CHK && (d_p_in ^ d_n_in) != 8'hFF) m_err <= 1'b1;
      end else m_run <= m_run + 1;
    end else if (out_ready) begin
      m_phase <= 0;
    end
  end

  function automatic logic [19:0] model_out();
    logic hold;
    hold = m_phase == 2;
    return {m_phase == 1 && in_valid && m_run + 1 == EVAL_CYC, m_phase != 1, hold, m_err,
            hold ? m_p : 8'h00, hold ? m_n : 8'h00};
  endfunction

  function automatic logic [19:0] dut_out();
    return {in_ready, prech_out, out_valid, rail_err, d_p_out, d_n_out};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit iv, input logic [7:0] p, input logic [7:0] n,
                     input bit o);
    @(negedge clk);
    rst_n = r; in_valid = iv; d_p_in = p; d_n_in = n; out_ready = o;
    #1;
    if (m_valid) chk("model {ir,prech,ov,err,p,n}", {12'b0, dut_out()}, {12'b0, model_out()});
  endtask

  typedef struct {
    bit r, iv;
    logic [7:0] p, n;
    bit o, chk;
    logic [19:0] exp;
  } vec_t;

  function automatic vec_t v(bit r, bit iv, logic [7:0] p, logic [7:0] n, bit o, bit c,
                             bit ir, bit pre, bit ov, logic [7:0] ep, logic [7:0] en);
    vec_t x;
    x.r = r; x.iv = iv; x.p = p; x.n = n; x.o = o; x.chk = c;
    x.exp = {ir, pre, ov, 1'b0, ep, en};
    return x;
  endfunction

  vec_t tbl[23];

  initial begin
    tbl = '{
      v(0,0,8'h00,8'h00,0, 0, 0,1,0,8'h00,8'h00),
      v(0,0,8'h00,8'h00,0, 1, 0,1,0,8'h00,8'h00),
      v(1,0,8'h00,8'h00,0, 1, 0,1,0,8'h00,8'h00),
      v(1,1,8'hA5,8'h5A,1, 1, 0,0,0,8'h00,8'h00),
      v(1,1,8'hA5,8'h5A,1, 1, 1,0,0,8'h00,8'h00),
      v(1,0,8'h00,8'h00,1, 1, 0,1,1,8'hA5,8'h5A),
      v(1,1,8'hFF,8'h00,1, 1, 0,1,0,8'h00,8'h00),
      v(1,1,8'h3C,8'hC3,0, 1, 0,0,0,8'h00,8'h00),
      v(1,0,8'h3C,8'hC3,0, 1, 0,0,0,8'h00,8'h00),
      v(1,1,8'h3C,8'hC3,0, 1, 0,0,0,8'h00,8'h00),
      v(1,1,8'h3C,8'hC3,0, 1, 1,0,0,8'h00,8'h00),
      v(1,1,8'h11,8'hEE,0, 1, 0,1,1,8'h3C,8'hC3),
      v(1,1,8'h11,8'hEE,0, 1, 0,1,1,8'h3C,8'hC3),
      v(1,1,8'h11,8'hEE,0, 1, 0,1,1,8'h3C,8'hC3),
      v(1,1,8'h11,8'hEE,0, 1, 0,1,1,8'h3C,8'hC3),
      v(1,1,8'h11,8'hEE,0, 1, 0,1,1,8'h3C,8'hC3),
      v(1,0,8'h00,8'h00,1, 1, 0,1,1,8'h3C,8'hC3),
      v(1,0,8'h00,8'h00,0, 1, 0,1,0,8'h00,8'h00),
      v(1,1,8'h77,8'h88,0, 1, 0,0,0,8'h00,8'h00),
      v(1,1,8'h77,8'h88,0, 1, 1,0,0,8'h00,8'h00),
      v(0,0,8'h00,8'h00,0, 1, 0,1,1,8'h77,8'h88),
      v(1,0,8'h00,8'h00,1, 1, 0,1,0,8'h00,8'h00),
      v(1,0,8'h00,8'h00,0, 1, 0,0,0,8'h00,8'h00)
    };
    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].r, tbl[i].iv, tbl[i].p, tbl[i].n, tbl[i].o);
      if (tbl[i].chk) chk($sformatf("vec%0d", i), {12'b0, dut_out()}, {12'b0, tbl[i].exp});
    end

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] p;
      p = 8'($urandom);
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 7, p,
          ($urandom_range(0, 7) == 0) ? 8'($urandom) : ~p, 1'($urandom));
    end

    cyc(0, 0, 8'h00, 8'h00, 0);
    cyc(0, 0, 8'h00, 8'h00, 0);
    cyc(1, 0, 8'h00, 8'h00, 0);
    cyc(1, 1, 8'h01, 8'h03, 1);
    cyc(1, 1, 8'h01, 8'h03, 1);
    cyc(1, 0, 8'h00, 8'h00, 1);
    chk("rail_err_set", {31'b0, rail_err}, {31'b0, RAIL_CHK});
    chk("bad_word_captured", {16'b0, d_p_out, d_n_out}, 32'h0103);
    cyc(1, 0, 8'h00, 8'h00, 1);
    cyc(1, 1, 8'hA5, 8'h5A, 1);
    cyc(1, 1, 8'hA5, 8'h5A, 1);
    cyc(1, 0, 8'h00, 8'h00, 1);
    chk("rail_err_sticky", {31'b0, rail_err}, {31'b0, RAIL_CHK});
    chk("clean_word_out", {16'b0, d_p_out, d_n_out}, 32'hA55A);
    cyc(0, 0, 8'h00, 8'h00, 0);
    cyc(1, 0, 8'h00, 8'h00, 0);
    chk("rail_err_cleared", {31'b0, rail_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
